// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring-mode CORDIC: (x, y) to (magnitude, angle)
// One micro-rotation per clock after a quadrant pre-rotation; gain applied in SCALE.
module cordic_vectoring #(
  parameter int ITER = 12
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic        busy,
  output logic        done,
  output logic [16:0] magnitude,
  output logic [16:0] angle
);

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_SCALE} state_t;

  state_t state, state_n;

  logic signed [18:0] xr, yr;
  logic signed [16:0] zr;
  logic        [3:0]  cnt;
  logic               zero_flag;

  logic signed [18:0] xi, yi, xs, ys;
  logic signed [33:0] prod;
  logic        [16:0] mag_next;

  function automatic logic signed [16:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 17'sd12867;
      4'd1:    atan_lut = 17'sd7596;
      4'd2:    atan_lut = 17'sd4013;
      4'd3:    atan_lut = 17'sd2037;
      4'd4:    atan_lut = 17'sd1022;
      4'd5:    atan_lut = 17'sd511;
      4'd6:    atan_lut = 17'sd255;
      4'd7:    atan_lut = 17'sd127;
      4'd8:    atan_lut = 17'sd63;
      4'd9:    atan_lut = 17'sd31;
      4'd10:   atan_lut = 17'sd15;
      4'd11:   atan_lut = 17'sd7;
      default: atan_lut = 17'sd0;
    endcase
  endfunction

  // Three guard bits keep negation of -32768 and CORDIC growth from wrapping.
  assign xi = {{3{x_in[15]}}, x_in};
  assign yi = {{3{y_in[15]}}, y_in};
  assign xs = xr >>> cnt;
  assign ys = yr >>> cnt;

  // 9949 = 0.60725 * 2^14 removes the CORDIC gain.
  assign prod     = 34'(xr) * 34'sd9949;
  assign mag_next = 17'(prod >>> 14);

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_ITER;
      ST_ITER:  if (cnt == 4'(ITER - 1)) state_n = ST_SCALE;
      ST_SCALE: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      magnitude <= '0;
      angle     <= '0;
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      cnt       <= '0;
      zero_flag <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt       <= '0;
            zero_flag <= (x_in == 16'd0) && (y_in == 16'd0);
            // Pre-rotate the left half-plane by +/-pi/2 so iterations see X >= 0.
            if (!x_in[15]) begin
              xr <= xi;
              yr <= yi;
              zr <= 17'sd0;
            end else if (!y_in[15]) begin
              xr <= yi;
              yr <= -xi;
              zr <= 17'sd25736;
            end else begin
              xr <= -yi;
              yr <= xi;
              zr <= -17'sd25736;
            end
          end
        end
        ST_ITER: begin
          cnt <= cnt + 4'd1;
          if (!yr[18]) begin
            xr <= xr + ys;
            yr <= yr - xs;
            zr <= zr + atan_lut(cnt);
          end else begin
            xr <= xr - ys;
            yr <= yr + xs;
            zr <= zr - atan_lut(cnt);
          end
        end
        ST_SCALE: begin
          magnitude <= zero_flag ? 17'd0 : mag_next;
          angle     <= zero_flag ? 17'd0 : zr;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - scoreboard bench for cordic_vectoring
module tb_cordic_vectoring;

  localparam int ITER = 12;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        busy;
  logic        done;
  logic [16:0] magnitude;
  logic [16:0] angle;

  int checks = 0;
  int passed = 0;
  int overlap_cnt = 0;

  typedef struct {
    int x;
    int y;
    int mag;
    int ang;
    int tm;
    int ta;
  } exp_t;

  exp_t sb[$];

  cordic_vectoring #(.ITER(ITER)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .magnitude (magnitude),
    .angle     (angle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (busy && done) overlap_cnt++;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ideal_mag(input int x, input int y);
    return $rtoi($sqrt(real'(x) * real'(x) + real'(y) * real'(y)) + 0.5);
  endfunction

  function automatic int ideal_ang(input int x, input int y);
    real a;
    a = $atan2(real'(y), real'(x)) * 16384.0;
    return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
  endfunction

  // Bit-level reference of the fixed-point algorithm, written with plain integers.
  function automatic void model(input int x, input int y, output int mag, output int ang);
    int at[12] = '{12867, 7596, 4013, 2037, 1022, 511, 255, 127, 63, 31, 15, 7};
    int cx, cy, cz, nx;
    if (x >= 0)     begin cx = x;  cy = y;  cz = 0;      end
    else if (y >= 0) begin cx = y;  cy = -x; cz = 25736;  end
    else             begin cx = -y; cy = x;  cz = -25736; end
    for (int i = 0; i < ITER; i++) begin
      if (cy >= 0) begin nx = cx + (cy >>> i); cy = cy - (cx >>> i); cz = cz + at[i]; end
      else         begin nx = cx - (cy >>> i); cy = cy + (cx >>> i); cz = cz - at[i]; end
      cx = nx;
    end
    mag = ((cx * 9949) >>> 14) & 32'h1FFFF;
    ang = cz;
    if (x == 0 && y == 0) begin mag = 0; ang = 0; end
  endfunction

  task automatic run_conv(input int x, input int y, input bit poke,
                          output int mag, output int ang, output int lat);
    @(negedge clock);
    start = 1'b1; x_in = 16'(x); y_in = 16'(y);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; x_in = 16'($urandom); y_in = 16'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      start = poke && (k < 9) && (k % 2 == 1);
      if (poke) begin x_in = 16'($urandom); y_in = 16'($urandom); end
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    mag = int'(magnitude);
    ang = $signed(angle);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; x_in = '0; y_in = '0;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passed++;
    checks++; if (magnitude !== 17'd0) $display("FAIL reset_mag got %0d want 0", magnitude); else passed++;
    checks++; if (angle !== 17'd0) $display("FAIL reset_angle got %0d want 0", angle); else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_axis;
    int tx[2] = '{16384, 0};
    int ty[2] = '{0, 16384};
    int ea[2] = '{0, 25736};
    int mag, ang, lat;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{tx[i], ty[i], 16384, ea[i], 4, 8});
      run_conv(tx[i], ty[i], 1'b0, mag, ang, lat);
      e = sb.pop_front();
      checks++; if (lat !== ITER + 1) $display("FAIL axis_latency got %0d want %0d", lat, ITER + 1); else passed++;
      checks++; if (iabs(mag - e.mag) > e.tm) $display("FAIL axis_mag (%0d,%0d) got %0d want %0d+-%0d", e.x, e.y, mag, e.mag, e.tm); else passed++;
      checks++; if (iabs(ang - e.ang) > e.ta) $display("FAIL axis_angle (%0d,%0d) got %0d want %0d+-%0d", e.x, e.y, ang, e.ang, e.ta); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    int dcount, mag, ang, lat;
    exp_t e;
    @(negedge clock);
    start = 1'b1; x_in = 16'd16384; y_in = 16'd16384;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_busy got %0b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL midreset_done got %0b want 0", done); else passed++;
    checks++; if (magnitude !== 17'd0) $display("FAIL midreset_mag got %0d want 0", magnitude); else passed++;
    checks++; if (angle !== 17'd0) $display("FAIL midreset_angle got %0d want 0", angle); else passed++;
    dcount = 0;
    repeat (30) begin @(negedge clock); if (done) dcount++; end
    checks++; if (dcount !== 0) $display("FAIL midreset_nodone got %0d done pulses want 0", dcount); else passed++;
    sb.push_back('{3000, -4000, 5000, ideal_ang(3000, -4000), 4, 8});
    run_conv(3000, -4000, 1'b0, mag, ang, lat);
    e = sb.pop_front();
    checks++; if (lat !== ITER + 1) $display("FAIL midreset_follow_latency got %0d want %0d", lat, ITER + 1); else passed++;
    checks++; if (iabs(mag - e.mag) > e.tm) $display("FAIL midreset_follow_mag got %0d want %0d", mag, e.mag); else passed++;
    checks++; if (iabs(ang - e.ang) > e.ta) $display("FAIL midreset_follow_angle got %0d want %0d", ang, e.ang); else passed++;
  endtask

  task automatic test_negative;
    int tx[2] = '{-16384, -11585};
    int ty[2] = '{0, -11585};
    int ea[2] = '{51472, -38604};
    int mag, ang, lat;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{tx[i], ty[i], 16384, ea[i], 4, 8});
      run_conv(tx[i], ty[i], 1'b0, mag, ang, lat);
      e = sb.pop_front();
      checks++; if (lat !== ITER + 1) $display("FAIL neg_latency got %0d want %0d", lat, ITER + 1); else passed++;
      checks++; if (iabs(mag - e.mag) > e.tm) $display("FAIL neg_mag (%0d,%0d) got %0d want %0d+-%0d", e.x, e.y, mag, e.mag, e.tm); else passed++;
      checks++; if (iabs(ang - e.ang) > e.ta) $display("FAIL neg_angle (%0d,%0d) got %0d want %0d+-%0d", e.x, e.y, ang, e.ang, e.ta); else passed++;
    end
  endtask

  task automatic test_extreme;
    int tx[2] = '{0, -32768};
    int ty[2] = '{0, -32768};
    int em[2] = '{0, 46341};
    int ea[2] = '{0, -38604};
    int tm[2] = '{0, 6};
    int ta[2] = '{0, 8};
    int mag, ang, lat;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{tx[i], ty[i], em[i], ea[i], tm[i], ta[i]});
      run_conv(tx[i], ty[i], 1'b0, mag, ang, lat);
      e = sb.pop_front();
      checks++; if (lat !== ITER + 1) $display("FAIL extreme_latency got %0d want %0d", lat, ITER + 1); else passed++;
      checks++; if (iabs(mag - e.mag) > e.tm) $display("FAIL extreme_mag (%0d,%0d) got %0d want %0d+-%0d", e.x, e.y, mag, e.mag, e.tm); else passed++;
      checks++; if (iabs(ang - e.ang) > e.ta) $display("FAIL extreme_angle (%0d,%0d) got %0d want %0d+-%0d", e.x, e.y, ang, e.ang, e.ta); else passed++;
    end
  endtask

  task automatic test_ignore_start;
    int mag, ang, lat, em, ea;
    exp_t e;
    model(-16384, 0, em, ea);
    sb.push_back('{-16384, 0, em, ea, 0, 0});
    run_conv(-16384, 0, 1'b1, mag, ang, lat);
    e = sb.pop_front();
    checks++; if (lat !== ITER + 1) $display("FAIL ignore_latency got %0d want %0d", lat, ITER + 1); else passed++;
    checks++; if (mag !== e.mag) $display("FAIL ignore_mag got %0d want %0d", mag, e.mag); else passed++;
    checks++; if (ang !== e.ang) $display("FAIL ignore_angle got %0d want %0d", ang, e.ang); else passed++;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) $display("FAIL ignore_idle_after got busy=%0b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back;
    int vx[4] = '{16384, 0, -8000, 12000};
    int vy[4] = '{0, -16384, 3000, 12000};
    int idx, cyc, got, last_done, em, ea, mag, ang;
    exp_t e;
    @(negedge clock);
    start = 1'b1; x_in = 16'(vx[0]); y_in = 16'(vy[0]);
    model(vx[0], vy[0], em, ea);
    sb.push_back('{vx[0], vy[0], em, ea, 0, 0});
    idx = 1; cyc = 0; got = 0; last_done = -1;
    while (got < 4 && cyc < 200) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (done) begin
        e = sb.pop_front();
        mag = int'(magnitude);
        ang = $signed(angle);
        checks++; if (mag !== e.mag) $display("FAIL b2b_mag (%0d,%0d) got %0d want %0d", e.x, e.y, mag, e.mag); else passed++;
        checks++; if (ang !== e.ang) $display("FAIL b2b_angle (%0d,%0d) got %0d want %0d", e.x, e.y, ang, e.ang); else passed++;
        if (last_done >= 0) begin
          checks++; if (cyc - last_done !== ITER + 2) $display("FAIL b2b_spacing got %0d want %0d", cyc - last_done, ITER + 2); else passed++;
        end
        last_done = cyc;
        got++;
        if (idx < 4) begin
          x_in = 16'(vx[idx]); y_in = 16'(vy[idx]);
          model(vx[idx], vy[idx], em, ea);
          sb.push_back('{vx[idx], vy[idx], em, ea, 0, 0});
          idx++;
        end else begin
          start = 1'b0;
        end
      end else begin
        x_in = 16'($urandom); y_in = 16'($urandom);
      end
    end
    start = 1'b0;
    checks++; if (got !== 4) $display("FAIL b2b_count got %0d results want 4", got); else passed++;
    sb.delete();
  endtask

  task automatic test_random;
    int x, y, em, ea, mag, ang, lat;
    exp_t e;
    for (int i = 0; i < 1000; i++) begin
      x = int'($urandom_range(65535)) - 32768;
      y = int'($urandom_range(65535)) - 32768;
      model(x, y, em, ea);
      sb.push_back('{x, y, em, ea, 0, 0});
      run_conv(x, y, (i % 5) == 0, mag, ang, lat);
      e = sb.pop_front();
      checks++; if (lat !== ITER + 1) $display("FAIL rand_latency got %0d want %0d", lat, ITER + 1); else passed++;
      checks++; if (mag !== e.mag) $display("FAIL rand_mag (%0d,%0d) got %0d want %0d", e.x, e.y, mag, e.mag); else passed++;
      checks++; if (ang !== e.ang) $display("FAIL rand_angle (%0d,%0d) got %0d want %0d", e.x, e.y, ang, e.ang); else passed++;
      if (iabs(x) >= 4096 || iabs(y) >= 4096) begin
        checks++; if (iabs(mag - ideal_mag(x, y)) > 16) $display("FAIL rand_ideal_mag (%0d,%0d) got %0d want %0d", x, y, mag, ideal_mag(x, y)); else passed++;
        checks++; if (iabs(ang - ideal_ang(x, y)) > 24) $display("FAIL rand_ideal_angle (%0d,%0d) got %0d want %0d", x, y, ang, ideal_ang(x, y)); else passed++;
      end
    end
  endtask

  task automatic test_invariants;
    checks++; if (overlap_cnt !== 0) $display("FAIL busy_done_overlap got %0d cycles want 0", overlap_cnt); else passed++;
  endtask

  initial begin
    test_reset;
    test_axis;
    test_reset_mid;
    test_negative;
    test_extreme;
    test_ignore_start;
    test_back_to_back;
    test_random;
    test_invariants;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
